// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and byte-lane helpers for the sequential load/store unit.
package lsu_pkg;

    localparam logic [5:0] OP_LW = 6'b001010;
    localparam logic [5:0] OP_SW = 6'b001011;
    localparam logic [5:0] OP_LB = 6'b001100;
    localparam logic [5:0] OP_SB = 6'b001101;

    localparam logic [2:0] READY = 3'b010;

    // Field placement measured down from the slot entry MSB.
    localparam int OPC_W   = 6;
    localparam int OFF_W   = 16;
    localparam int RS_GAP  = 6;
    localparam int RT_GAP  = 16;
    localparam int OFF_GAP = 21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FAULT  = 2'd3
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_LB) || (op == OP_SB);
    endfunction

    function automatic logic is_word_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    // Little-endian lane select: lane 0 is bits [7:0].
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] rep_byte(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/lsu_slot_arb.sv
// Highest-index priority picker over the ready slot vector.
module lsu_slot_arb #(
    parameter int SLOTS = 8,
    parameter int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic [SLOTS-1:0] ready,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |ready;
        idx   = '0;
        // Ascending scan so the last (highest) ready slot overrides.
        for (int i = 0; i < SLOTS; i++) begin
            if (ready[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lsu_seq.sv
// Sequential LSU: picks one ready LW/SW/LB/SB slot, performs a req/ack memory access,
// writes back loads and stamps the slot. One access in flight at a time.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int SLOTS  = 8,
    parameter int INSN_W = 88,
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int ST_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SLOTS*ST_W-1:0]   reg_start_flat,
    input  logic [SLOTS*INSN_W-1:0] reg_out_flat,
    output logic [SLOTS*ST_W-1:0]   stamp_flat,
    output logic [SLOTS-1:0]        stamp_in,
    output logic [RA_W-1:0]         reg_search_out10,
    input  logic [XLEN-1:0]         reg_out10,
    output logic [RA_W-1:0]         reg_search_out11,
    input  logic [XLEN-1:0]         reg_out11,
    output logic [RA_W-1:0]         reg_search_in10,
    output logic [XLEN-1:0]         reg_in10,
    output logic                    reg_in10_start,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [XLEN/8-1:0]       mem_be,
    output logic [XLEN-1:0]         mem_addr,
    output logic [XLEN-1:0]         mem_wdata,
    input  logic                    mem_ack,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic                    fault,
    output logic                    busy
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BE_W  = XLEN / 8;

    lsu_state_e state_reg, state_next;

    logic [IDX_W-1:0] slot_reg;
    logic [5:0]       op_reg;
    logic [RA_W-1:0]  rd_reg;
    logic [XLEN-1:0]  ea_reg;
    logic [XLEN-1:0]  data_reg;
    logic [XLEN-1:0]  rdata_reg;
    logic             insn2_reg;
    logic             insn0_reg;

    logic [SLOTS-1:0] ready;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_ready
            logic [OPC_W-1:0] slot_op;
            assign slot_op   = reg_out_flat[gi*INSN_W + INSN_W - 1 -: OPC_W];
            assign ready[gi] = is_mem_op(slot_op) &&
                               (reg_start_flat[gi*ST_W +: ST_W] == ST_W'(READY));
        end
    endgenerate

    lsu_slot_arb #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .ready (ready),
        .valid (win_valid),
        .idx   (win_idx)
    );

    logic [INSN_W-1:0] win_insn;
    logic [5:0]        win_op;
    logic [RA_W-1:0]   win_rs;
    logic [RA_W-1:0]   win_rt;
    logic [OFF_W-1:0]  win_off;
    logic [XLEN-1:0]   win_ea;
    logic              issue;
    logic              win_misaligned;
    logic              unused_insn;

    assign win_insn       = reg_out_flat[int'(win_idx)*INSN_W +: INSN_W];
    assign win_op         = win_insn[INSN_W-1 -: OPC_W];
    assign win_rs         = win_insn[INSN_W-1-RS_GAP -: RA_W];
    assign win_rt         = win_insn[INSN_W-1-RT_GAP -: RA_W];
    assign win_off        = win_insn[INSN_W-1-OFF_GAP -: OFF_W];
    assign win_ea         = reg_out10 + {{(XLEN-OFF_W){win_off[OFF_W-1]}}, win_off};
    assign win_misaligned = is_word_op(win_op) && (win_ea[1:0] != 2'b00);
    assign issue          = (state_reg == ST_IDLE) && win_valid && !reset;
    assign unused_insn    = ^win_insn;

    // Register-file read addresses only reflect a winner while one can actually issue.
    assign reg_search_out10 = issue ? win_rs : '0;
    assign reg_search_out11 = issue ? win_rt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            slot_reg  <= '0;
            op_reg    <= '0;
            rd_reg    <= '0;
            ea_reg    <= '0;
            data_reg  <= '0;
            rdata_reg <= '0;
            insn2_reg <= 1'b0;
            insn0_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (issue) begin
                slot_reg  <= win_idx;
                op_reg    <= win_op;
                rd_reg    <= win_rt;
                ea_reg    <= win_ea;
                data_reg  <= reg_out11;
                insn2_reg <= win_insn[2];
                insn0_reg <= win_insn[0];
            end
            if ((state_reg == ST_REQ) && mem_ack) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    logic       stamp_hit;
    logic [7:0] load_byte;

    always_comb begin
        state_next      = state_reg;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_be          = '0;
        mem_addr        = '0;
        mem_wdata       = '0;
        reg_search_in10 = '0;
        reg_in10        = '0;
        reg_in10_start  = 1'b0;
        fault           = 1'b0;
        stamp_hit       = 1'b0;
        load_byte       = lane_byte(rdata_reg[31:0], ea_reg[1:0]);

        case (state_reg)
            ST_IDLE: begin
                if (issue) begin
                    state_next = win_misaligned ? ST_FAULT : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_addr = ea_reg;
                mem_we   = is_store_op(op_reg);
                mem_be   = is_word_op(op_reg) ? {BE_W{1'b1}} : (BE_W'(1) << ea_reg[1:0]);
                if (op_reg == OP_SW) begin
                    mem_wdata = data_reg;
                end else if (op_reg == OP_SB) begin
                    mem_wdata = XLEN'(rep_byte(data_reg[7:0]));
                end
                if (mem_ack) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                stamp_hit = 1'b1;
                if (!is_store_op(op_reg)) begin
                    reg_in10_start  = 1'b1;
                    reg_search_in10 = rd_reg;
                    reg_in10        = (op_reg == OP_LW) ? rdata_reg
                                    : {{(XLEN-8){load_byte[7]}}, load_byte};
                end
                state_next = ST_IDLE;
            end
            ST_FAULT: begin
                fault      = 1'b1;
                stamp_hit  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic [ST_W-1:0] stamp_code;

    assign stamp_code = ST_W'({insn2_reg, 1'b1, insn0_reg});
    assign stamp_in   = stamp_hit ? (SLOTS'(1) << slot_reg) : '0;
    assign busy       = (state_reg != ST_IDLE);

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_stamp
            assign stamp_flat[gi*ST_W +: ST_W] = stamp_in[gi] ? stamp_code : '0;
        end
    endgenerate

endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: directed scenarios plus randomized slot tables
// checked against a behavioural model of the slot pick, address math and lane rules.
module tb_lsu_seq;

    localparam int SLOTS  = 8;
    localparam int INSN_W = 88;
    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int ST_W   = 3;

    localparam logic [5:0] T_LW = 6'b001010;
    localparam logic [5:0] T_SW = 6'b001011;
    localparam logic [5:0] T_LB = 6'b001100;
    localparam logic [5:0] T_SB = 6'b001101;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [SLOTS*ST_W-1:0]   reg_start_flat;
    logic [SLOTS*INSN_W-1:0] reg_out_flat;
    logic [SLOTS*ST_W-1:0]   stamp_flat;
    logic [SLOTS-1:0]        stamp_in;
    logic [RA_W-1:0]         reg_search_out10, reg_search_out11, reg_search_in10;
    logic [XLEN-1:0]         reg_out10, reg_out11, reg_in10;
    logic                    reg_in10_start;
    logic                    mem_req, mem_we, mem_ack, fault, busy;
    logic [XLEN/8-1:0]       mem_be;
    logic [XLEN-1:0]         mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lsu_seq #(
        .SLOTS(SLOTS), .INSN_W(INSN_W), .XLEN(XLEN), .RA_W(RA_W), .ST_W(ST_W)
    ) dut (
        .clk(clk), .reset(reset),
        .reg_start_flat(reg_start_flat), .reg_out_flat(reg_out_flat),
        .stamp_flat(stamp_flat), .stamp_in(stamp_in),
        .reg_search_out10(reg_search_out10), .reg_out10(reg_out10),
        .reg_search_out11(reg_search_out11), .reg_out11(reg_out11),
        .reg_search_in10(reg_search_in10), .reg_in10(reg_in10), .reg_in10_start(reg_in10_start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fault(fault), .busy(busy)
    );

    // Slot table and register file models driving the DUT.
    logic [2:0]        status [SLOTS];
    logic [INSN_W-1:0] insn   [SLOTS];
    logic [31:0]       rf     [32];

    always_comb begin
        reg_start_flat = '0;
        reg_out_flat   = '0;
        for (int k = 0; k < SLOTS; k++) begin
            reg_start_flat[k*ST_W +: ST_W]     = status[k];
            reg_out_flat[k*INSN_W +: INSN_W]   = insn[k];
        end
    end

    assign reg_out10 = rf[reg_search_out10];
    assign reg_out11 = rf[reg_search_out11];

    logic [151:0] all_out;
    assign all_out = {stamp_flat, stamp_in, reg_search_out10, reg_search_out11, reg_search_in10,
                      reg_in10, reg_in10_start, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                      fault, busy};

    int n_checks = 0;
    int n_fail   = 0;

    // Observed transaction record filled by observe().
    bit          obs_req_seen, obs_unstable, obs_wr_en, obs_wr_outside, obs_fault;
    logic [31:0] obs_addr, obs_wdata, obs_wr_data;
    logic [3:0]  obs_be;
    logic        obs_we;
    logic [4:0]  obs_wr_addr;
    logic [7:0]  obs_stamp_in;
    logic [23:0] obs_stamp_flat;
    int          obs_latency;

    function automatic logic [INSN_W-1:0] mk_insn(input logic [5:0] op, input logic [4:0] rs,
                                                  input logic [4:0] rt, input logic [15:0] off,
                                                  input logic [2:0] lo);
        logic [INSN_W-1:0] v;
        v[31:0]  = $urandom();
        v[63:32] = $urandom();
        v[87:64] = 24'($urandom());
        v[87:82] = op;
        v[81:77] = rs;
        v[71:67] = rt;
        v[66:51] = off;
        v[2:0]   = lo;
        return v;
    endfunction

    function automatic bit tb_is_mem(input logic [5:0] op);
        return (op == T_LW) || (op == T_SW) || (op == T_LB) || (op == T_SB);
    endfunction

    task automatic clear_table();
        for (int k = 0; k < SLOTS; k++) begin
            status[k] = 3'b000;
            insn[k]   = '0;
        end
    endtask

    // Serves one access: acks after ack_delay extra REQ cycles, records what the DUT did
    // up to and including the stamp cycle, then retires the stamped slot in the table.
    task automatic observe(input int ack_delay, input logic [31:0] rdata, input bit scramble);
        int first_busy = 0;
        int req_n = 0;
        bit got_busy = 0;
        obs_req_seen = 0; obs_unstable = 0; obs_wr_en = 0; obs_wr_outside = 0; obs_fault = 0;
        obs_addr = '0; obs_wdata = '0; obs_wr_data = '0; obs_be = '0; obs_we = 0;
        obs_wr_addr = '0; obs_stamp_in = '0; obs_stamp_flat = '0; obs_latency = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (busy && !got_busy) begin
                got_busy   = 1;
                first_busy = c;
                if (scramble) begin
                    for (int k = 0; k < SLOTS; k++) insn[k][81:0] = {$urandom(), $urandom(), 18'($urandom())};
                    for (int r = 0; r < 32; r++) rf[r] = $urandom();
                end
            end
            if (mem_req) begin
                req_n++;
                if (!obs_req_seen) begin
                    obs_req_seen = 1;
                    obs_addr = mem_addr; obs_be = mem_be; obs_we = mem_we; obs_wdata = mem_wdata;
                end else if (mem_addr !== obs_addr || mem_wdata !== obs_wdata) begin
                    obs_unstable = 1;
                end
                if (req_n == ack_delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (stamp_in != '0) begin
                obs_stamp_in = stamp_in; obs_stamp_flat = stamp_flat; obs_fault = fault;
                obs_wr_en = reg_in10_start; obs_wr_addr = reg_search_in10; obs_wr_data = reg_in10;
                obs_latency = c - first_busy + 1;
                for (int k = 0; k < SLOTS; k++) if (stamp_in[k]) status[k] = 3'b101;
                break;
            end else if (reg_in10_start) begin
                obs_wr_outside = 1;
            end
        end
        $display("txn: stamp=%b flat=%h fault=%0d req=%0d addr=%h be=%b we=%0d wdata=%h wr=%0d rd=%0d wdata_rf=%h lat=%0d",
                 obs_stamp_in, obs_stamp_flat, obs_fault, obs_req_seen, obs_addr, obs_be, obs_we,
                 obs_wdata, obs_wr_en, obs_wr_addr, obs_wr_data, obs_latency);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_table();
        status[5] = 3'b010;
        insn[5]   = mk_insn(T_LW, 5'd1, 5'd2, 16'h0000, 3'b000);
        rf[1]     = 32'h0000_0100;
        repeat (3) @(negedge clk);
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        status[5] = 3'b000;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_lw();
        clear_table();
        rf[2] = 32'h0000_0100;
        insn[3] = mk_insn(T_LW, 5'd2, 5'd7, 16'd4, 3'b101);
        status[3] = 3'b010;
        observe(2, 32'hDEAD_BEEF, 0);
        n_checks++; if (obs_addr !== 32'h104) begin n_fail++; $display("FAIL lw_addr: got %h expected 104", obs_addr); end
        n_checks++; if (obs_be !== 4'hF || obs_we !== 1'b0) begin n_fail++; $display("FAIL lw_be_we: got %b/%b expected 1111/0", obs_be, obs_we); end
        n_checks++; if (obs_unstable) begin n_fail++; $display("FAIL lw_stable: got unstable expected stable"); end
        n_checks++; if (!obs_wr_en || obs_wr_addr !== 5'd7 || obs_wr_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL lw_write: got en=%b rd=%0d %h expected en=1 rd=7 deadbeef", obs_wr_en, obs_wr_addr, obs_wr_data); end
        n_checks++; if (obs_stamp_in !== 8'b0000_1000) begin n_fail++; $display("FAIL lw_stamp: got %b expected 00001000", obs_stamp_in); end
        n_checks++; if (obs_stamp_flat !== 24'(3'b111) << 9) begin n_fail++; $display("FAIL lw_stamp_flat: got %h expected %h", obs_stamp_flat, 24'(3'b111) << 9); end
        n_checks++; if (obs_latency !== 4) begin n_fail++; $display("FAIL lw_latency: got %0d expected 4", obs_latency); end
    endtask

    task automatic test_lb();
        clear_table();
        rf[4] = 32'h0000_0200;
        insn[7] = mk_insn(T_LB, 5'd4, 5'd9, 16'd3, 3'b100);
        status[7] = 3'b010;
        observe(1, 32'h8012_3456, 0);
        n_checks++; if (obs_addr !== 32'h203 || obs_be !== 4'b1000) begin n_fail++; $display("FAIL lb_addr_be: got %h/%b expected 203/1000", obs_addr, obs_be); end
        n_checks++; if (!obs_wr_en || obs_wr_addr !== 5'd9 || obs_wr_data !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb_write: got en=%b rd=%0d %h expected en=1 rd=9 ffffff80", obs_wr_en, obs_wr_addr, obs_wr_data); end
        n_checks++; if (obs_stamp_flat !== 24'(3'b110) << 21) begin n_fail++; $display("FAIL lb_stamp_flat: got %h expected %h", obs_stamp_flat, 24'(3'b110) << 21); end
    endtask

    task automatic test_sb();
        clear_table();
        rf[5] = 32'h0000_0011;
        rf[6] = 32'h0000_00A5;
        insn[0] = mk_insn(T_SB, 5'd5, 5'd6, 16'd0, 3'b000);
        status[0] = 3'b010;
        observe(0, 32'h1234_5678, 0);
        n_checks++; if (obs_be !== 4'b0010 || obs_we !== 1'b1 || obs_wdata !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL sb_access: got be=%b we=%b %h expected 0010 1 a5a5a5a5", obs_be, obs_we, obs_wdata); end
        n_checks++; if (obs_wr_en || obs_wr_outside) begin n_fail++; $display("FAIL sb_no_write: got write expected none"); end
        n_checks++; if (obs_stamp_in !== 8'b0000_0001 || obs_stamp_flat !== 24'h000002) begin
            n_fail++; $display("FAIL sb_stamp: got %b/%h expected 00000001/000002", obs_stamp_in, obs_stamp_flat); end
    endtask

    task automatic test_priority();
        clear_table();
        rf[8] = 32'h0000_0040;
        rf[9] = 32'h0000_0080;
        insn[1] = mk_insn(T_LW, 5'd8, 5'd3, 16'd0, 3'b001);
        insn[6] = mk_insn(T_LW, 5'd9, 5'd4, 16'd8, 3'b001);
        status[1] = 3'b010;
        status[6] = 3'b010;
        observe(0, 32'h0000_0006, 0);
        n_checks++; if (obs_stamp_in !== 8'b0100_0000 || obs_addr !== 32'h88) begin
            n_fail++; $display("FAIL prio_first: got %b/%h expected 01000000/88", obs_stamp_in, obs_addr); end
        n_checks++; if (obs_latency !== 2) begin n_fail++; $display("FAIL prio_latency: got %0d expected 2", obs_latency); end
        observe(0, 32'h0000_0001, 0);
        n_checks++; if (obs_stamp_in !== 8'b0000_0010 || obs_addr !== 32'h40 || obs_wr_data !== 32'h1) begin
            n_fail++; $display("FAIL prio_second: got %b/%h/%h expected 00000010/40/1", obs_stamp_in, obs_addr, obs_wr_data); end
    endtask

    task automatic test_fault();
        clear_table();
        rf[10] = 32'h0000_0100;
        insn[2] = mk_insn(T_LW, 5'd10, 5'd3, 16'd2, 3'b011);
        status[2] = 3'b010;
        observe(0, 32'h0, 0);
        n_checks++; if (!obs_fault || obs_stamp_in !== 8'b0000_0100) begin
            n_fail++; $display("FAIL fault_stamp: got fault=%b stamp=%b expected 1/00000100", obs_fault, obs_stamp_in); end
        n_checks++; if (obs_req_seen || obs_wr_en || obs_wr_outside) begin
            n_fail++; $display("FAIL fault_side_effects: got req=%b wr=%b expected none", obs_req_seen, obs_wr_en); end
        n_checks++; if (obs_stamp_flat !== 24'h0000C0 || obs_latency !== 1) begin
            n_fail++; $display("FAIL fault_flat_lat: got %h/%0d expected 0000c0/1", obs_stamp_flat, obs_latency); end
    endtask

    task automatic test_reset_in_req();
        bit seen = 0;
        bit leak = 0;
        clear_table();
        rf[12] = 32'h0000_0300;
        insn[4] = mk_insn(T_LW, 5'd12, 5'd5, 16'd0, 3'b111);
        status[4] = 3'b010;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_req;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_req_reached: got no mem_req expected mem_req"); end
        reset = 1'b1;
        status[4] = 3'b000;
        @(negedge clk);
        n_checks++; if (all_out !== '0) begin n_fail++; $display("FAIL rst_in_req_outputs: got %h expected 0", all_out); end
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        repeat (4) begin
            @(negedge clk);
            if (stamp_in != '0 || reg_in10_start || mem_req || busy) leak = 1;
        end
        mem_ack = 1'b0;
        n_checks++; if (leak) begin n_fail++; $display("FAIL rst_late_ack: got activity expected none"); end
        $display("txn: reset during REQ, late ack ignored=%0d", !leak);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int win = -1;
            int soff, lane, ack_delay, bv;
            logic [5:0]  op;
            logic [4:0]  rs, rt;
            logic [15:0] off;
            logic [31:0] ea, rdata, exp_load;
            bit          word, store, exp_fault;
            for (int k = 0; k < SLOTS; k++) begin
                case ($urandom_range(0, 4))
                    0: op = T_LW;
                    1: op = T_SW;
                    2: op = T_LB;
                    3: op = T_SB;
                    default: op = 6'($urandom());
                endcase
                status[k] = ($urandom_range(0, 2) == 0) ? 3'b010 : 3'($urandom());
                insn[k]   = mk_insn(op, 5'($urandom()), 5'($urandom()), 16'($urandom()), 3'($urandom()));
            end
            for (int r = 0; r < 32; r++) begin
                rf[r] = $urandom();
                if ($urandom_range(0, 1) == 0) rf[r][1:0] = 2'b00;
            end
            for (int k = 0; k < SLOTS; k++)
                if (status[k] == 3'b010 && tb_is_mem(insn[k][87:82])) win = k;
            if (win < 0) begin
                win = $urandom_range(0, SLOTS - 1);
                status[win] = 3'b010;
                insn[win][87:82] = T_LB;
            end
            op = insn[win][87:82]; rs = insn[win][81:77]; rt = insn[win][71:67]; off = insn[win][66:51];
            soff = int'($signed(off));
            ea = rf[rs] + 32'(soff);
            lane = int'(ea % 4);
            word = (op == T_LW) || (op == T_SW);
            store = (op == T_SW) || (op == T_SB);
            exp_fault = word && (lane != 0);
            rdata = $urandom();
            bv = int'((rdata >> (8 * lane)) & 32'hFF);
            exp_load = (op == T_LW) ? rdata : ((bv >= 128) ? 32'(bv - 256) : 32'(bv));
            ack_delay = $urandom_range(0, 3);
            begin
                logic [31:0] exp_wdata;
                logic [2:0]  exp_code;
                exp_wdata = (op == T_SW) ? rf[rt] : {4{rf[rt][7:0]}};
                exp_code  = {insn[win][2], 1'b1, insn[win][0]};
                observe(ack_delay, rdata, 1);
                n_checks++; if (obs_stamp_in !== 8'(1 << win)) begin n_fail++; $display("FAIL rnd_stamp: got %b expected %b", obs_stamp_in, 8'(1 << win)); end
                n_checks++; if (obs_stamp_flat !== (24'(exp_code) << (3 * win))) begin n_fail++; $display("FAIL rnd_stamp_flat: got %h expected %h", obs_stamp_flat, 24'(exp_code) << (3 * win)); end
                n_checks++; if (obs_fault !== exp_fault || obs_req_seen !== !exp_fault) begin
                    n_fail++; $display("FAIL rnd_fault: got fault=%b req=%b expected fault=%b", obs_fault, obs_req_seen, exp_fault); end
                n_checks++; if (obs_latency !== (exp_fault ? 1 : ack_delay + 2)) begin
                    n_fail++; $display("FAIL rnd_latency: got %0d expected %0d", obs_latency, exp_fault ? 1 : ack_delay + 2); end
                n_checks++; if (obs_wr_outside || obs_wr_en !== (!store && !exp_fault)) begin
                    n_fail++; $display("FAIL rnd_wr_en: got %b expected %b", obs_wr_en, !store && !exp_fault); end
                if (!exp_fault) begin
                    n_checks++; if (obs_addr !== ea || obs_unstable) begin n_fail++; $display("FAIL rnd_addr: got %h expected %h", obs_addr, ea); end
                    n_checks++; if (obs_be !== (word ? 4'hF : 4'(1 << lane)) || obs_we !== store) begin
                        n_fail++; $display("FAIL rnd_be_we: got %b/%b expected %b/%b", obs_be, obs_we, word ? 4'hF : 4'(1 << lane), store); end
                    if (store) begin
                        n_checks++; if (obs_wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd_wdata: got %h expected %h", obs_wdata, exp_wdata); end
                    end else begin
                        n_checks++; if (obs_wr_addr !== rt || obs_wr_data !== exp_load) begin
                            n_fail++; $display("FAIL rnd_load: got rd=%0d %h expected rd=%0d %h", obs_wr_addr, obs_wr_data, rt, exp_load); end
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int r = 0; r < 32; r++) rf[r] = '0;
        clear_table();
        test_reset();
        test_lw();
        test_lb();
        test_sb();
        test_priority();
        test_fault();
        test_reset_in_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
